memory_access_cycle: RTL and testbench

- MEM stage of the RV32 pipeline; consumes the EX/MEM outputs of the execution cycle (ALUOutM, StoreCounterOutM, ALUSelectM, WriteAddressM, control bits).
- Drives a request/acknowledge data-memory port: byte-lane strobes for stores, sign/zero extension for loads.
- Stalls upstream while an access is outstanding, and registers results into the MEM/WB boundary for the writeback cycle.

---
 rtl/mem_pkg.sv | 47 ++++
 rtl/memory_access_cycle_align.sv | 50 +++++
 rtl/memory_access_cycle.sv | 195 +++++++++++++++++++
 tb/tb_memory_access_cycle.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared MEM-stage definitions: load/store op codes,
// fault cause codes, FSM states and small op helpers.
package mem_pkg;

    localparam logic [5:0] opLb  = 6'b001011;
    localparam logic [5:0] opLh  = 6'b001100;
    localparam logic [5:0] opLw  = 6'b001101;
    localparam logic [5:0] opLbu = 6'b001110;
    localparam logic [5:0] opLhu = 6'b001111;
    localparam logic [5:0] opSb  = 6'b010000;
    localparam logic [5:0] opSh  = 6'b010001;
    localparam logic [5:0] opSw  = 6'b010010;

    typedef enum logic [1:0] {
        causeNone       = 2'b00,
        causeMisaligned = 2'b01,
        causeTimeout    = 2'b10,
        causeIllegal    = 2'b11
    } faultCause_e;

    typedef enum logic {
        stateIdle   = 1'b0,
        stateAccess = 1'b1
    } memState_e;

    function automatic logic isLoad(input logic [5:0] op);
        return op inside {opLb, opLh, opLw, opLbu, opLhu};
    endfunction

    function automatic logic isStore(input logic [5:0] op);
        return op inside {opSb, opSh, opSw};
    endfunction

    function automatic logic isMisaligned(
        input logic [5:0] op,
        input logic [1:0] addrLo
    );
        logic bad;
        bad = 1'b0;
        if (op inside {opLw, opSw})
            bad = (addrLo != 2'b00);
        else if (op inside {opLh, opLhu, opSh})
            bad = addrLo[0];
        return bad;
    endfunction

endpackage

// File: rtl/memory_access_cycle_align.sv
// load_store_align: store lane replication/strobes and
// load byte/half extraction with sign or zero extension.
// Ports: op, addrLo, storeData, loadRaw in;
//        storeWData, byteEn, loadData out.
module load_store_align
    import mem_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addrLo,
    input  logic [31:0] storeData,
    input  logic [31:0] loadRaw,
    output logic [31:0] storeWData,
    output logic [3:0]  byteEn,
    output logic [31:0] loadData
);

    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    always_comb begin
        storeWData = storeData;
        byteEn     = 4'b0000;
        case (op)
            opSb: begin
                storeWData = {4{storeData[7:0]}};
                byteEn     = 4'b0001 << addrLo;
            end
            opSh: begin
                storeWData = {2{storeData[15:0]}};
                byteEn     = addrLo[1] ? 4'b1100 : 4'b0011;
            end
            opSw: byteEn = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        loadByte = loadRaw[{addrLo, 3'b000} +: 8];
        loadHalf = addrLo[1] ? loadRaw[31:16] : loadRaw[15:0];
        case (op)
            opLb:    loadData = {{24{loadByte[7]}}, loadByte};
            opLbu:   loadData = {24'h0, loadByte};
            opLh:    loadData = {{16{loadHalf[15]}}, loadHalf};
            opLhu:   loadData = {16'h0, loadHalf};
            opLw:    loadData = loadRaw;
            default: loadData = 32'h0;
        endcase
    end

endmodule

// File: rtl/memory_access_cycle.sv
// MEM stage: drives the req/ack data-memory port, stalls
// upstream while an access is outstanding, raises fault
// pulses and registers results into the MEM/WB boundary.
// Ports: EX/MEM inputs (ALUOutM..MemWriteM), DMem* port,
//        StallM, FaultM/FaultCauseM, W-side outputs.
module memory_access_cycle
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TCNT_W         = 5
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] StoreCounterOutM,
    input  logic [5:0]  ALUSelectM,
    input  logic [4:0]  WriteAddressM,
    input  logic        JtypeM,
    input  logic        RegWriteM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    output logic [31:0] DMemAddr,
    output logic [31:0] DMemWData,
    output logic [3:0]  DMemByteEn,
    output logic        DMemReq,
    output logic        DMemWrite,
    input  logic [31:0] DMemRData,
    input  logic        DMemAck,
    output logic        StallM,
    output logic        FaultM,
    output logic [1:0]  FaultCauseM,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteAddressW,
    output logic        RegWriteW,
    output logic        MemReadW,
    output logic        JtypeW
);

    memState_e         state, stateNext;
    logic [TCNT_W-1:0] timeCnt;
    logic [5:0]        opQ;
    logic [1:0]        addrLoQ;

    logic memOp, legalOp, badAddr, timeoutHit;
    logic stallNow, doCapture, doComplete;
    logic doTimeout, doFault, passThrough;
    faultCause_e faultCause;

    logic [5:0]  alignOp;
    logic [1:0]  alignAddr;
    logic [31:0] alignWData, alignLoad;
    logic [3:0]  alignByteEn;

    assign memOp   = MemReadM | MemWriteM;
    assign legalOp =
        (MemReadM & ~MemWriteM & isLoad(ALUSelectM)) |
        (MemWriteM & ~MemReadM & isStore(ALUSelectM));
    assign badAddr = isMisaligned(ALUSelectM, ALUOutM[1:0]);
    assign timeoutHit =
        (timeCnt == TCNT_W'(TIMEOUT_CYCLES - 1));

    // Store formatting is needed at capture (IDLE), load
    // formatting at completion (ACCESS), so one aligner
    // serves both by switching its operand source.
    assign alignOp   = (state == stateAccess) ? opQ
                                              : ALUSelectM;
    assign alignAddr = (state == stateAccess) ? addrLoQ
                                              : ALUOutM[1:0];

    load_store_align uAlign (
        .op        (alignOp),
        .addrLo    (alignAddr),
        .storeData (StoreCounterOutM),
        .loadRaw   (DMemRData),
        .storeWData(alignWData),
        .byteEn    (alignByteEn),
        .loadData  (alignLoad)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= stateIdle;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        stallNow   = 1'b0;
        doCapture  = 1'b0;
        doComplete = 1'b0;
        doTimeout  = 1'b0;
        doFault    = 1'b0;
        faultCause = causeNone;
        case (state)
            stateIdle: begin
                if (memOp) begin
                    if (!legalOp) begin
                        doFault    = 1'b1;
                        faultCause = causeIllegal;
                    end else if (badAddr) begin
                        doFault    = 1'b1;
                        faultCause = causeMisaligned;
                    end else begin
                        stallNow  = 1'b1;
                        doCapture = 1'b1;
                        stateNext = stateAccess;
                    end
                end
            end
            stateAccess: begin
                if (DMemAck) begin
                    doComplete = 1'b1;
                    stateNext  = stateIdle;
                end else if (timeoutHit) begin
                    doTimeout  = 1'b1;
                    doFault    = 1'b1;
                    faultCause = causeTimeout;
                    stateNext  = stateIdle;
                end else begin
                    stallNow = 1'b1;
                end
            end
            default: stateNext = stateIdle;
        endcase
    end

    // Stall is released while reset is held so upstream
    // is not frozen by the reset-forced IDLE state.
    assign StallM = stallNow & RESET_N;

    assign passThrough = doComplete |
        ((state == stateIdle) & ~memOp);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            DMemAddr    <= 32'h0;
            DMemWData   <= 32'h0;
            DMemByteEn  <= 4'b0000;
            DMemReq     <= 1'b0;
            DMemWrite   <= 1'b0;
            opQ         <= 6'h0;
            addrLoQ     <= 2'b00;
            timeCnt     <= '0;
        end else if (doCapture) begin
            DMemAddr    <= {ALUOutM[31:2], 2'b00};
            DMemWData   <= MemWriteM ? alignWData : 32'h0;
            DMemByteEn  <= MemWriteM ? alignByteEn
                                     : 4'b0000;
            DMemReq     <= 1'b1;
            DMemWrite   <= MemWriteM;
            opQ         <= ALUSelectM;
            addrLoQ     <= ALUOutM[1:0];
            timeCnt     <= '0;
        end else if (doComplete | doTimeout) begin
            DMemByteEn  <= 4'b0000;
            DMemReq     <= 1'b0;
            DMemWrite   <= 1'b0;
        end else if (state == stateAccess) begin
            timeCnt     <= timeCnt + TCNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            FaultM        <= 1'b0;
            FaultCauseM   <= causeNone;
            ReadDataW     <= 32'h0;
            ALUOutW       <= 32'h0;
            WriteAddressW <= 5'h0;
            RegWriteW     <= 1'b0;
            MemReadW      <= 1'b0;
            JtypeW        <= 1'b0;
        end else begin
            FaultM      <= doFault;
            FaultCauseM <= faultCause;
            if (passThrough) begin
                ReadDataW <= (doComplete & ~DMemWrite)
                           ? alignLoad : 32'h0;
                ALUOutW       <= ALUOutM;
                WriteAddressW <= WriteAddressM;
                RegWriteW     <= RegWriteM;
                MemReadW      <= MemReadM;
                JtypeW        <= JtypeM;
            end else begin
                ReadDataW     <= 32'h0;
                ALUOutW       <= 32'h0;
                WriteAddressW <= 5'h0;
                RegWriteW     <= 1'b0;
                MemReadW      <= 1'b0;
                JtypeW        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_cycle.sv
// Self-checking bench for memory_access_cycle: directed
// cases plus randomized ops against a behavioural model.
module tb_memory_access_cycle;

    localparam int TO = 16;

    localparam logic [5:0] LB  = 6'b001011;
    localparam logic [5:0] LH  = 6'b001100;
    localparam logic [5:0] LW  = 6'b001101;
    localparam logic [5:0] LBU = 6'b001110;
    localparam logic [5:0] LHU = 6'b001111;
    localparam logic [5:0] SB  = 6'b010000;
    localparam logic [5:0] SH  = 6'b010001;
    localparam logic [5:0] SW  = 6'b010010;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] ALUOutM, StoreCounterOutM;
    logic [5:0]  ALUSelectM;
    logic [4:0]  WriteAddressM;
    logic        JtypeM, RegWriteM, MemReadM, MemWriteM;
    logic [31:0] DMemAddr, DMemWData, DMemRData;
    logic [3:0]  DMemByteEn;
    logic        DMemReq, DMemWrite, DMemAck;
    logic        StallM, FaultM;
    logic [1:0]  FaultCauseM;
    logic [31:0] ReadDataW, ALUOutW;
    logic [4:0]  WriteAddressW;
    logic        RegWriteW, MemReadW, JtypeW;

    memory_access_cycle #(
        .TIMEOUT_CYCLES(TO),
        .TCNT_W(5)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .ALUOutM(ALUOutM),
        .StoreCounterOutM(StoreCounterOutM),
        .ALUSelectM(ALUSelectM),
        .WriteAddressM(WriteAddressM),
        .JtypeM(JtypeM), .RegWriteM(RegWriteM),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .DMemAddr(DMemAddr), .DMemWData(DMemWData),
        .DMemByteEn(DMemByteEn), .DMemReq(DMemReq),
        .DMemWrite(DMemWrite), .DMemRData(DMemRData),
        .DMemAck(DMemAck), .StallM(StallM),
        .FaultM(FaultM), .FaultCauseM(FaultCauseM),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW),
        .WriteAddressW(WriteAddressW),
        .RegWriteW(RegWriteW), .MemReadW(MemReadW),
        .JtypeW(JtypeW)
    );

    always #5 CLK = ~CLK;

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            if (nFail <= 40)
                $display("FAIL %s: actual %0h required %0h @%0t",
                         name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit isLd(input logic [5:0] op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic bit isSt(input logic [5:0] op);
        return op inside {SB, SH, SW};
    endfunction

    function automatic int sizeOf(input logic [5:0] op);
        if (op inside {LB, LBU, SB}) return 1;
        if (op inside {LH, LHU, SH}) return 2;
        return 4;
    endfunction

    // 0 none, 1 illegal, 2 misaligned, 3 memory access
    function automatic int classify();
        int sz;
        if (!MemReadM && !MemWriteM) return 0;
        if ((MemReadM && MemWriteM) ||
            (MemReadM && !isLd(ALUSelectM)) ||
            (MemWriteM && !isSt(ALUSelectM))) return 1;
        sz = sizeOf(ALUSelectM);
        if ((int'(ALUOutM[1:0]) % sz) != 0) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] loadValue(
        input logic [5:0] op, input logic [1:0] off,
        input logic [31:0] raw);
        int sz;
        logic [31:0] v, mask;
        sz = sizeOf(op);
        v = raw >> (8 * int'(off));
        mask = (sz == 4) ? 32'hFFFF_FFFF
                         : (32'h1 << (8 * sz)) - 32'h1;
        v = v & mask;
        if ((op == LB || op == LH) && v[8 * sz - 1])
            v = v | ~mask;
        return v;
    endfunction

    bit          mBusy;
    int          mAge;
    logic [5:0]  mOp;
    logic [1:0]  mOff;
    bit          mWrite;
    logic        eReq, eWrite, eFault;
    logic [1:0]  eCause;
    logic [31:0] eAddr, eWData, eRd, eAlu;
    logic [3:0]  eBe;
    logic [4:0]  eWa;
    logic        eRw, eMr, eJ;

    function automatic bit expStall();
        if (!RESET_N) return 0;
        if (mBusy) return !DMemAck && (mAge < TO - 1);
        return classify() == 3;
    endfunction

    task automatic bubbleW();
        eRd = 0; eAlu = 0; eWa = 0;
        eRw = 0; eMr = 0; eJ = 0;
    endtask

    task automatic loadW(input logic [31:0] rd);
        eRd = rd; eAlu = ALUOutM; eWa = WriteAddressM;
        eRw = RegWriteM; eMr = MemReadM; eJ = JtypeM;
    endtask

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mBusy = 0; mAge = 0; eReq = 0; eWrite = 0;
            eFault = 0; eCause = 0; eAddr = 0;
            eWData = 0; eBe = 0;
            bubbleW();
        end else begin
            eFault = 0; eCause = 0;
            if (mBusy) begin
                if (DMemAck) begin
                    loadW(mWrite ? 32'h0
                                 : loadValue(mOp, mOff, DMemRData));
                    mBusy = 0; eReq = 0;
                end else if (mAge == TO - 1) begin
                    bubbleW();
                    eFault = 1; eCause = 2'd2;
                    mBusy = 0; eReq = 0;
                end else begin
                    mAge++;
                    bubbleW();
                end
            end else begin
                case (classify())
                    0: loadW(32'h0);
                    1: begin bubbleW(); eFault = 1; eCause = 2'd3; end
                    2: begin bubbleW(); eFault = 1; eCause = 2'd1; end
                    default: begin
                        int sz, off;
                        bubbleW();
                        mBusy = 1; mAge = 0;
                        mOp = ALUSelectM; mOff = ALUOutM[1:0];
                        mWrite = MemWriteM;
                        sz = sizeOf(mOp); off = int'(mOff);
                        eReq = 1; eWrite = MemWriteM;
                        eAddr = ALUOutM & 32'hFFFF_FFFC;
                        eBe = 0; eWData = 0;
                        if (mWrite)
                            for (int i = 0; i < 4; i++) begin
                                eBe[i] = (i >= off) && (i < off + sz);
                                eWData[8*i +: 8] =
                                    StoreCounterOutM[8*(i % sz) +: 8];
                            end
                    end
                endcase
            end
        end
    end

    always @(negedge CLK) begin
        if (RESET_N) begin
            check("StallM", StallM, expStall());
            check("DMemReq", DMemReq, eReq);
            if (eReq) begin
                check("DMemAddr", DMemAddr, eAddr);
                check("DMemWData", DMemWData, eWData);
                check("DMemByteEn", DMemByteEn, eBe);
                check("DMemWrite", DMemWrite, eWrite);
            end
            check("FaultM", FaultM, eFault);
            check("FaultCauseM", FaultCauseM, eCause);
            check("ReadDataW", ReadDataW, eRd);
            check("ALUOutW", ALUOutW, eAlu);
            check("WriteAddressW", WriteAddressW, eWa);
            check("RegWriteW", RegWriteW, eRw);
            check("MemReadW", MemReadW, eMr);
            check("JtypeW", JtypeW, eJ);
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] snapAddr, snapWData;
    logic [3:0]  snapBe;
    int          stalls, reqs;

    // Present one op in MEM and hold it while stalled.
    // ackDelay: ACCESS cycles before ack, <0 means never.
    task automatic runOp(
        input logic [5:0] op, input bit rd, input bit wr,
        input logic [31:0] addr, input logic [31:0] data,
        input logic [4:0] wa, input bit rw, input bit j,
        input int ackDelay, input logic [31:0] rdata,
        output int nStall, output int nReq);
        bit done, s;
        ALUSelectM = op; MemReadM = rd; MemWriteM = wr;
        ALUOutM = addr; StoreCounterOutM = data;
        WriteAddressM = wa; RegWriteM = rw; JtypeM = j;
        DMemRData = rdata;
        nStall = 0; nReq = 0; done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (mBusy)
                DMemAck = (ackDelay >= 0) && (mAge == ackDelay);
            else
                DMemAck = ($urandom_range(0, 3) == 0);
            #1;
            if (DMemReq) begin
                nReq++;
                if (nReq == 1) begin
                    snapAddr = DMemAddr;
                    snapWData = DMemWData;
                    snapBe = DMemByteEn;
                end
            end
            s = expStall();
            if (s) nStall++;
            @(posedge CLK); #1;
            if (!s) done = 1;
        end
        DMemAck = 0;
        if (!done) begin
            nFail++; nChecks++;
            $display("FAIL runOp: op %0h never left MEM", op);
        end
    endtask

    logic [5:0]  memOps [8];
    logic [5:0]  rOp;
    bit          rRd, rWr;
    logic [31:0] rAddr;
    int          rKind, rDelay, rSz;

    initial begin
        memOps = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
        RESET_N = 1; ALUOutM = 0; StoreCounterOutM = 0;
        ALUSelectM = 0; WriteAddressM = 0; JtypeM = 0;
        RegWriteM = 0; MemReadM = 0; MemWriteM = 0;
        DMemRData = 0; DMemAck = 0;
        #1 RESET_N = 0;
        #2;
        check("rst DMemReq", DMemReq, 0);
        check("rst DMemByteEn", DMemByteEn, 0);
        check("rst FaultM", FaultM, 0);
        check("rst FaultCauseM", FaultCauseM, 0);
        check("rst RegWriteW", RegWriteW, 0);
        check("rst ALUOutW", ALUOutW, 0);
        check("rst StallM", StallM, 0);
        repeat (2) @(posedge CLK);
        #3 RESET_N = 1;
        @(posedge CLK); #1;

        runOp(6'h00, 0, 0, 32'h5, 0, 5'd10, 1, 0, 0, 0,
              stalls, reqs);
        check("add ALUOutW", ALUOutW, 32'h5);
        check("add WriteAddressW", WriteAddressW, 5'd10);
        check("add RegWriteW", RegWriteW, 1);
        check("add stalls", stalls, 0);

        runOp(SW, 0, 1, 32'h100, 32'hDEAD_BEEF, 5'd0, 0, 0,
              0, 0, stalls, reqs);
        check("sw DMemAddr", snapAddr, 32'h100);
        check("sw ByteEn", snapBe, 4'hF);
        check("sw WData", snapWData, 32'hDEAD_BEEF);
        check("sw stalls", stalls, 1);
        check("sw reqs", reqs, 1);

        runOp(LB, 1, 0, 32'h103, 0, 5'd3, 1, 0, 3,
              32'h80FF_7F01, stalls, reqs);
        check("lb ReadDataW", ReadDataW, 32'hFFFF_FF80);
        check("lb stalls", stalls, 4);
        runOp(LBU, 1, 0, 32'h103, 0, 5'd3, 1, 0, 3,
              32'h80FF_7F01, stalls, reqs);
        check("lbu ReadDataW", ReadDataW, 32'h0000_0080);
        runOp(LH, 1, 0, 32'h102, 0, 5'd3, 1, 0, 3,
              32'h80FF_7F01, stalls, reqs);
        check("lh ReadDataW", ReadDataW, 32'hFFFF_80FF);

        runOp(SB, 0, 1, 32'h202, 32'h0000_00A5, 5'd0, 0, 0,
              0, 0, stalls, reqs);
        check("sb ByteEn", snapBe, 4'b0100);
        check("sb WData", snapWData, 32'hA5A5_A5A5);

        runOp(SH, 0, 1, 32'h101, 32'h1234, 5'd4, 1, 0, 0, 0,
              stalls, reqs);
        check("sh-mis FaultM", FaultM, 1);
        check("sh-mis cause", FaultCauseM, 2'b01);
        check("sh-mis RegWriteW", RegWriteW, 0);
        check("sh-mis reqs", reqs, 0);
        check("sh-mis stalls", stalls, 0);

        runOp(LW, 1, 1, 32'h100, 0, 5'd4, 1, 0, 0, 0,
              stalls, reqs);
        check("illegal cause", FaultCauseM, 2'b11);
        check("illegal reqs", reqs, 0);

        runOp(LW, 1, 0, 32'h40, 0, 5'd6, 1, 0, -1, 0,
              stalls, reqs);
        check("timeout reqs", reqs, 16);
        check("timeout stalls", stalls, 16);
        check("timeout FaultM", FaultM, 1);
        check("timeout cause", FaultCauseM, 2'b10);
        check("timeout DMemReq", DMemReq, 0);

        // reset in the middle of an access
        ALUSelectM = LW; MemReadM = 1; MemWriteM = 0;
        ALUOutM = 32'h200; RegWriteM = 1; WriteAddressM = 7;
        DMemAck = 0;
        repeat (2) begin @(posedge CLK); #1; end
        check("pre-rst DMemReq", DMemReq, 1);
        #1 RESET_N = 0;
        #1;
        check("midrst DMemReq", DMemReq, 0);
        check("midrst StallM", StallM, 0);
        check("midrst RegWriteW", RegWriteW, 0);
        check("midrst MemReadW", MemReadW, 0);
        MemReadM = 0; ALUSelectM = 0; ALUOutM = 32'h77;
        WriteAddressM = 2; RegWriteM = 1;
        @(posedge CLK); #3 RESET_N = 1;
        @(posedge CLK); #1;
        DMemAck = 1;
        @(posedge CLK); #1;
        DMemAck = 0;
        check("late-ack DMemReq", DMemReq, 0);
        check("late-ack ALUOutW", ALUOutW, 32'h77);
        check("late-ack FaultM", FaultM, 0);
        runOp(LW, 1, 0, 32'h204, 0, 5'd9, 1, 0, 1,
              32'h1234_5678, stalls, reqs);
        check("post-rst ReadDataW", ReadDataW, 32'h1234_5678);
        check("post-rst reqs", reqs, 2);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            rKind = $urandom_range(0, 9);
            rOp = memOps[$urandom_range(0, 7)];
            rRd = isLd(rOp); rWr = !rRd;
            rAddr = $urandom;
            rSz = sizeOf(rOp);
            if (rKind <= 5) begin
                if (rSz == 2) rAddr[0] = 1'b0;
                if (rSz == 4) rAddr[1:0] = 2'b00;
            end else if (rKind == 7 || rKind == 8) begin
                rRd = 0; rWr = 0;
                rOp = 6'($urandom_range(0, 10));
            end else if (rKind == 9) begin
                case ($urandom_range(0, 2))
                    0: begin rRd = 1; rWr = 1; end
                    1: begin rRd = 1; rWr = 0;
                             rOp = 6'($urandom_range(0, 10)); end
                    default: begin rRd = 0; rWr = 1;
                             rOp = memOps[$urandom_range(0, 4)]; end
                endcase
            end
            rDelay = ($urandom_range(0, 19) == 0)
                   ? -1 : int'($urandom_range(0, 4));
            runOp(rOp, rRd, rWr, rAddr, $urandom,
                  5'($urandom), 1'($urandom), 1'($urandom),
                  rDelay, $urandom, stalls, reqs);
        end

        MemReadM = 0; MemWriteM = 0;
        repeat (3) @(posedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFail);
        $finish;
    end

endmodule
